serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Optional zero flag output is enabled by SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
package serial_subtractor_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module Full_Subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_ZERO_FLAG_EN to add the Zero_Out result flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic                  Start_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic [DATA_WIDTH-1:0] Difference_Out,
    output logic                  Borrow_Out
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    ,
    output logic                  Zero_Out
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-2:0] res_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  borrow_q;

    logic                  fs_d;
    logic                  fs_bout;
    logic [DATA_WIDTH-1:0] res_next;

    // Result bits enter at the MSB end so the full word is aligned after the last bit.
    assign res_next = {fs_d, res_q};

    Full_Subtractor u_full_subtractor (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            res_q          <= '0;
            cnt_q          <= '0;
            borrow_q       <= 1'b0;
            Busy_Out       <= 1'b0;
            Done_Out       <= 1'b0;
            Difference_Out <= '0;
            Borrow_Out     <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
            Zero_Out       <= 1'b0;
`endif
        end else begin
            Done_Out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start_In) begin
                        a_q      <= Data_A_In;
                        b_q      <= Data_B_In;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        Busy_Out <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    res_q    <= res_next[DATA_WIDTH-1:1];
                    borrow_q <= fs_bout;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q        <= DONE;
                        Busy_Out       <= 1'b0;
                        Done_Out       <= 1'b1;
                        Difference_Out <= res_next;
                        Borrow_Out     <= fs_bout;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
                        Zero_Out       <= (res_next == '0);
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (DATA_WIDTH=8): cycle-level model plus directed vectors.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    logic         zero;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    serial_subtractor #(.DATA_WIDTH(W)) dut (
        .Clock_In       (clk),
        .Reset_n_In     (rst_n),
        .Start_In       (start),
        .Data_A_In      (data_a),
        .Data_B_In      (data_b),
        .Busy_Out       (busy),
        .Done_Out       (done),
        .Difference_Out (diff),
        .Borrow_Out     (borrow)
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        ,
        .Zero_Out       (zero)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request yields its result W edges later, then one idle edge.
    int           m_left = -1;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] exp_diff = '0;
    logic         exp_borrow = 1'b0;
    logic         exp_zero = 1'b0;
    logic         exp_busy;
    logic         exp_done;

    assign exp_busy = (m_left > 0);
    assign exp_done = (m_left == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left     <= -1;
            m_a        <= '0;
            m_b        <= '0;
            exp_diff   <= '0;
            exp_borrow <= 1'b0;
            exp_zero   <= 1'b0;
        end else if (m_left == 0) begin
            m_left <= -1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                exp_diff   <= m_a - m_b;
                exp_borrow <= (m_a < m_b);
                exp_zero   <= (m_a == m_b);
            end
        end else if (start) begin
            m_a    <= data_a;
            m_b    <= data_b;
            m_left <= W;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("difference", 32'(diff), 32'(exp_diff));
            chk("borrow", 32'(borrow), 32'(exp_borrow));
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
            chk("zero", 32'(zero), 32'(exp_zero));
`endif
        end
    end

    // One full request with latency, busy-length and literal result checks.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb, input string tag);
        int n;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        data_a = a;
        data_b = b;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        n        = 1;
        busy_cnt = 0;
        seen     = 0;
        while (!seen && n < 30) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_cnt++;
                @(negedge clk);
                n++;
            end
        end
        chk({tag, "_latency"}, 32'(n), 32'd9);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
        @(negedge clk);
    endtask

    initial begin
        int dones;
        int last_done;
        int got;
        logic [W-1:0] seen_diff;
        logic         seen_borrow;

        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_borrow", 32'(borrow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h05, 8'h03, 8'h02, 1'b0, "5m3");
        do_op(8'h03, 8'h05, 8'hFE, 1'b1, "3m5");
        do_op(8'h00, 8'h01, 8'hFF, 1'b1, "0m1");
        do_op(8'hA5, 8'hA5, 8'h00, 1'b0, "a5ma5");
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        chk("a5ma5_zero", 32'(zero), 32'd1);
`endif
        do_op(8'h00, 8'hFF, 8'h01, 1'b1, "0mff");

        // Second start mid-operation must be ignored.
        @(negedge clk);
        data_a = 8'h10;
        data_b = 8'h01;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        data_a = 8'hFF;
        data_b = 8'h00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        seen_diff = '0;
        seen_borrow = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                seen_diff   = diff;
                seen_borrow = borrow;
            end
        end
        chk("ignore_start_dones", 32'(dones), 32'd1);
        chk("ignore_start_diff", 32'(seen_diff), 32'h0F);
        chk("ignore_start_borrow", 32'(seen_borrow), 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        data_a = 8'h55;
        data_b = 8'h11;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        do_op(8'h80, 8'h7F, 8'h01, 1'b0, "80m7f");

        // Back-to-back random operands with start held high.
        @(negedge clk);
        data_a = 8'($urandom);
        data_b = 8'($urandom);
        start  = 1'b1;
        last_done = 0;
        for (int i = 0; i < 200; i++) begin
            got = 0;
            for (int t = 0; t < 30 && got == 0; t++) begin
                @(negedge clk);
                if (done) got = 1;
            end
            chk("random_done_seen", 32'(got), 32'd1);
            if (i > 0) chk("random_spacing", 32'(cyc - last_done), 32'd10);
            last_done = cyc;
            data_a = 8'($urandom);
            data_b = 8'($urandom);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
